// File: rtl/a51_pkg.sv
// -----------------------------------------------------------------------------
// a51_pkg
// Shared definitions for the A5/1 keystream controller: controller state
// encoding, default sequence lengths, LFSR tap positions and a small helper
// used to size the shared bit counter.
// -----------------------------------------------------------------------------
package a51_pkg;

  // Controller phases, in the order a session walks through them.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_KEY   = 3'd2,
    ST_FRAME = 3'd3,
    ST_MIX   = 3'd4,
    ST_GEN   = 3'd5,
    ST_DONE  = 3'd6
  } a51_state_e;

  // Default sequence lengths.
  localparam int unsigned DEF_KEY_BITS   = 32'd64;
  localparam int unsigned DEF_FRAME_BITS = 32'd22;
  localparam int unsigned DEF_MIX_CYCLES = 32'd100;
  localparam int unsigned DEF_KS_BITS    = 32'd228;

  // Clocking tap positions inside the X/Y/Z registers (drive x/y/z_tap).
  localparam int unsigned X_CLK_TAP = 32'd8;
  localparam int unsigned Y_CLK_TAP = 32'd10;
  localparam int unsigned Z_CLK_TAP = 32'd10;

  // Output tap positions (MSBs of each register, drive x/y/z_out).
  localparam int unsigned X_OUT_TAP = 32'd18;
  localparam int unsigned Y_OUT_TAP = 32'd21;
  localparam int unsigned Z_OUT_TAP = 32'd22;

  // Largest of four lengths; sizes the counter shared by all phases.
  function automatic int unsigned max4(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c,
                                       input int unsigned d);
    int unsigned ab;
    int unsigned cd;
    ab = (a > b) ? a : b;
    cd = (c > d) ? c : d;
    return (ab > cd) ? ab : cd;
  endfunction

endpackage

// File: rtl/a51_keystream_ctrl_maj_vote.sv
// -----------------------------------------------------------------------------
// a51_maj_vote
// Majority clocking rule for the three A5/1 registers: a register steps only
// when its clocking tap agrees with the majority of the three taps, so at
// least two registers step on every enabled cycle.
//
// Ports:
//   x_tap_i, y_tap_i, z_tap_i : clocking taps of X, Y, Z
//   en_o[2:0]                 : step enables, bit 2 = X, bit 1 = Y, bit 0 = Z
// -----------------------------------------------------------------------------
module a51_maj_vote
  import a51_pkg::*;
(
  input  logic       x_tap_i,
  input  logic       y_tap_i,
  input  logic       z_tap_i,
  output logic [2:0] en_o
);

  logic maj_s;

  assign maj_s = (x_tap_i & y_tap_i) | (x_tap_i & z_tap_i) | (y_tap_i & z_tap_i);

  // XNOR with the majority: 1 where the tap agrees.
  assign en_o = {~(x_tap_i ^ maj_s), ~(y_tap_i ^ maj_s), ~(z_tap_i ^ maj_s)};

endmodule

// File: rtl/a51_keystream_ctrl.sv
// -----------------------------------------------------------------------------
// a51_keystream_ctrl
// Sequencer for an external A5/1 LFSR triple. Per session it clears the
// registers, serially loads the key and then the frame number (MSB first,
// all three registers stepping), runs the majority-clocked warm-up with no
// output, and finally delivers KS_BITS keystream bits over a valid/ready
// handshake before pulsing done.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start, key, frame   : session request; key/frame captured on acceptance
//   x/y/z_tap           : clocking taps from the registers
//   x/y/z_out           : output taps from the registers
//   lfsr_rst_n[2:0]     : active-low register clear (bit 2 = X)
//   lfsr_en[2:0]        : per-register step enable (bit 2 = X)
//   lfsr_shift_bit      : serial load bit shared by the three registers
//   ks_valid, ks_ready, ks_bit : keystream handshake
//   busy, done          : session in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module a51_keystream_ctrl
  import a51_pkg::*;
#(
  parameter int unsigned KEY_BITS   = DEF_KEY_BITS,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned MIX_CYCLES = DEF_MIX_CYCLES,
  parameter int unsigned KS_BITS    = DEF_KS_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_BITS-1:0]   key,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  x_tap,
  input  logic                  y_tap,
  input  logic                  z_tap,
  input  logic                  x_out,
  input  logic                  y_out,
  input  logic                  z_out,
  output logic [2:0]            lfsr_rst_n,
  output logic [2:0]            lfsr_en,
  output logic                  lfsr_shift_bit,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic                  ks_bit,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_MAX  = max4(KEY_BITS, FRAME_BITS, MIX_CYCLES, KS_BITS);
  localparam int unsigned CNT_W    = $clog2(CNT_MAX) + 32'd1;
  localparam int unsigned KEY_IW   = (KEY_BITS > 32'd1) ? $clog2(KEY_BITS) : 32'd1;
  localparam int unsigned FRAME_IW = (FRAME_BITS > 32'd1) ? $clog2(FRAME_BITS) : 32'd1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BITS - 32'd1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 32'd1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KS_BITS - 32'd1);

  a51_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [KEY_BITS-1:0]   key_q, key_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;

  logic [2:0]            maj_en_s;
  logic                  hs_s;
  logic [KEY_IW-1:0]     key_sel_s;
  logic [FRAME_IW-1:0]   frame_sel_s;

  a51_maj_vote u_maj_vote (
    .x_tap_i (x_tap),
    .y_tap_i (y_tap),
    .z_tap_i (z_tap),
    .en_o    (maj_en_s)
  );

  // ks_valid is high throughout GEN, so a handshake is GEN with ready.
  assign hs_s = (state_q == ST_GEN) & ks_ready;

  // The counter runs 0..N-1, so MSB-first selection is (N-1) - count.
  assign key_sel_s   = KEY_IW'(KEY_BITS - 32'd1) - cnt_q[KEY_IW-1:0];
  assign frame_sel_s = FRAME_IW'(FRAME_BITS - 32'd1) - cnt_q[FRAME_IW-1:0];

  // State, shared counter and captured session inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      key_q   <= {KEY_BITS{1'b0}};
      frame_q <= {FRAME_BITS{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      frame_q <= frame_d;
    end
  end

  // Next state and counter; the counter clears on every phase change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    frame_d = frame_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (start) begin
          state_d = ST_CLEAR;
          key_d   = key;
          frame_d = frame;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_KEY;
        cnt_d   = CNT_ZERO;
      end
      ST_KEY: begin
        if (cnt_q == KEY_LAST) begin
          state_d = ST_FRAME;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FRAME: begin
        if (cnt_q == FRAME_LAST) begin
          state_d = ST_MIX;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_MIX: begin
        if (cnt_q == MIX_LAST) begin
          state_d = ST_GEN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GEN: begin
        if (hs_s) begin
          if (cnt_q == KS_LAST) begin
            state_d = ST_DONE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here.
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs decoded from the current phase (and live taps in MIX/GEN).
  always_comb begin
    lfsr_rst_n     = 3'b111;
    lfsr_en        = 3'b000;
    lfsr_shift_bit = 1'b0;
    ks_valid       = 1'b0;
    ks_bit         = 1'b0;
    done           = 1'b0;
    busy           = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_CLEAR: begin
        lfsr_rst_n = 3'b000;
      end
      ST_KEY: begin
        lfsr_en        = 3'b111;
        lfsr_shift_bit = key_q[key_sel_s];
      end
      ST_FRAME: begin
        lfsr_en        = 3'b111;
        lfsr_shift_bit = frame_q[frame_sel_s];
      end
      ST_MIX: begin
        lfsr_en = maj_en_s;
      end
      ST_GEN: begin
        ks_valid = 1'b1;
        ks_bit   = x_out ^ y_out ^ z_out;
        // Registers only step when the current bit is consumed.
        if (hs_s) begin
          lfsr_en = maj_en_s;
        end else begin
          lfsr_en = 3'b000;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_a51_keystream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_a51_keystream_ctrl
// Directed bench for a51_keystream_ctrl. A timeline model (cycles since the
// accepted start, handshakes delivered) predicts every output each cycle;
// directed literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_a51_keystream_ctrl;

  localparam int KB    = 64;
  localparam int FB    = 22;
  localparam int MC    = 100;
  localparam int KS    = 228;
  localparam int GEN_T = 2 + KB + FB + MC;

  localparam logic [KB-1:0] K1 = 64'h5157455241534446;
  localparam logic [FB-1:0] F1 = 22'h34E191;
  localparam logic [KB-1:0] K2 = 64'hFEDCBA9876543210;
  localparam logic [FB-1:0] F2 = 22'h155555;
  localparam logic [KB-1:0] K3 = 64'h0123456789ABCDEF;
  localparam logic [FB-1:0] F3 = 22'h2AAAAA;
  localparam logic [10:0]   IDLE_VEC = 11'b111_000_0_0_0_0_0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KB-1:0] key = '0;
  logic [FB-1:0] frame = '0;
  logic          x_tap = 1'b0, y_tap = 1'b0, z_tap = 1'b0;
  logic          x_out = 1'b0, y_out = 1'b0, z_out = 1'b0;
  logic          ks_ready = 1'b1;
  logic [2:0]    lfsr_rst_n, lfsr_en;
  logic          lfsr_shift_bit, ks_valid, ks_bit, busy, done;

  int total = 0;
  int bad   = 0;
  int rel   = 0;
  bit hold_taps = 1'b0;
  bit chk_en    = 1'b0;

  // Timeline model: active session, cycles since acceptance, handshakes.
  bit            m_act = 1'b0;
  bit            m_done = 1'b0;
  int            m_t = 0;
  int            m_hs = 0;
  logic [KB-1:0] m_key = '0;
  logic [FB-1:0] m_frame = '0;

  always #5 clk = ~clk;

  a51_keystream_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .key            (key),
    .frame          (frame),
    .x_tap          (x_tap),
    .y_tap          (y_tap),
    .z_tap          (z_tap),
    .x_out          (x_out),
    .y_out          (y_out),
    .z_out          (z_out),
    .lfsr_rst_n     (lfsr_rst_n),
    .lfsr_en        (lfsr_en),
    .lfsr_shift_bit (lfsr_shift_bit),
    .ks_valid       (ks_valid),
    .ks_ready       (ks_ready),
    .ks_bit         (ks_bit),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t rel=%0d: got %0h expected %0h", nm, $time, rel, act, exp);
    end
  endtask

  // Model advance on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_act <= 1'b0; m_done <= 1'b0; m_t <= 0; m_hs <= 0;
      m_key <= '0; m_frame <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act <= 1'b1; m_t <= 1; m_hs <= 0; m_key <= key; m_frame <= frame;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t >= GEN_T && ks_ready) begin
        m_hs <= m_hs + 1;
        if (m_hs == KS - 1) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the timeline model.
  always @(negedge clk) begin : cmp
    logic [2:0] e_rst, e_en, e_maj;
    logic e_sb, e_v, e_b, e_busy, e_done, mj;
    #2;
    if (chk_en) begin
      mj    = ((int'(x_tap) + int'(y_tap) + int'(z_tap)) >= 2);
      e_maj = {x_tap == mj, y_tap == mj, z_tap == mj};
      e_rst = 3'b111; e_en = 3'b000; e_sb = 1'b0; e_v = 1'b0; e_b = 1'b0;
      e_busy = 1'b0; e_done = 1'b0;
      if (m_done) begin
        e_busy = 1'b1; e_done = 1'b1;
      end else if (m_act) begin
        e_busy = 1'b1;
        if (m_t == 1) begin
          e_rst = 3'b000;
        end else if (m_t < 2 + KB) begin
          e_en = 3'b111; e_sb = m_key[KB - 1 - (m_t - 2)];
        end else if (m_t < 2 + KB + FB) begin
          e_en = 3'b111; e_sb = m_frame[FB - 1 - (m_t - 2 - KB)];
        end else if (m_t < GEN_T) begin
          e_en = e_maj;
        end else begin
          e_v = 1'b1; e_b = x_out ^ y_out ^ z_out;
          e_en = ks_ready ? e_maj : 3'b000;
        end
      end
      check("outputs",
            64'({lfsr_rst_n, lfsr_en, lfsr_shift_bit, ks_valid, ks_bit, busy, done}),
            64'({e_rst, e_en, e_sb, e_v, e_b, e_busy, e_done}));
    end
  end

  task automatic nxt();
    @(negedge clk);
    if (!hold_taps) begin
      {x_tap, y_tap, z_tap, x_out, y_out, z_out} = 6'($urandom);
    end
  endtask

  task automatic adv_to(input int n);
    while (rel < n) begin
      nxt();
      rel++;
    end
  endtask

  task automatic start_session(input logic [KB-1:0] k, input logic [FB-1:0] f);
    start = 1'b1; key = k; frame = f;
    nxt();
    start = 1'b0; rel = 1;
  endtask

  initial begin
    // Reset state.
    nxt(); chk_en = 1'b1;
    nxt(); nxt();
    #3 check("reset_values",
             64'({lfsr_rst_n, lfsr_en, lfsr_shift_bit, ks_valid, ks_bit, busy, done}),
             64'(IDLE_VEC));
    reset = 1'b0;
    nxt();

    // Session 1: timing landmarks and key/frame MSBs.
    start_session(K1, F1);
    #3 check("clear_rst_n", 64'(lfsr_rst_n), 64'(3'b000));
    adv_to(2);  #3 check("key_bit0", 64'(lfsr_shift_bit), 64'(1'b0));
    adv_to(3);  #3 check("key_bit1", 64'(lfsr_shift_bit), 64'(1'b1));
    // start pulse with different key/frame during KEY must be ignored.
    adv_to(10); start = 1'b1; key = ~K1; frame = ~F1;
    adv_to(11); start = 1'b0;
    #3 check("key_bit9_after_pulse", 64'(lfsr_shift_bit), 64'(1'b1));
    adv_to(12); #3 check("key_bit10_after_pulse", 64'(lfsr_shift_bit), 64'(1'b0));
    adv_to(66); #3 check("frame_bit0", 64'(lfsr_shift_bit), 64'(1'b1));
    // Majority clocking in MIX.
    adv_to(100); {x_tap, y_tap, z_tap} = 3'b100;
    #3 check("mix_en_100", 64'(lfsr_en), 64'(3'b011));
    adv_to(101); {x_tap, y_tap, z_tap} = 3'b111;
    #3 check("mix_en_111", 64'(lfsr_en), 64'(3'b111));
    adv_to(102); {x_tap, y_tap, z_tap} = 3'b010;
    #3 check("mix_en_010", 64'(lfsr_en), 64'(3'b101));
    adv_to(187); #3 check("valid_before_gen", 64'(ks_valid), 64'(1'b0));
    adv_to(188); #3 check("valid_first", 64'(ks_valid), 64'(1'b1));
    // Backpressure for 5 cycles with held taps (x^y^z = 0).
    adv_to(200);
    hold_taps = 1'b1; ks_ready = 1'b0;
    {x_tap, y_tap, z_tap, x_out, y_out, z_out} = 6'b011_110;
    for (int s = 0; s < 5; s++) begin
      adv_to(200 + s);
      #3;
      check("stall_en", 64'(lfsr_en), 64'(3'b000));
      check("stall_bit", 64'(ks_bit), 64'(1'b0));
      check("stall_no_done", 64'(done), 64'(1'b0));
    end
    adv_to(205); hold_taps = 1'b0; ks_ready = 1'b1;
    // 228 handshakes: 12 before the stall, 216 from rel 205 -> last at 420.
    adv_to(420); #3 check("no_done_at_last_bit", 64'(done), 64'(1'b0));
    adv_to(421); start = 1'b1; key = K2; frame = F2;
    #3 check("done_pulse", 64'({busy, done}), 64'(2'b11));
    nxt(); rel = 422;
    #3 check("idle_after_done", 64'({busy, ks_valid, done}), 64'(3'b000));
    // start held through DONE is accepted on the first IDLE cycle.
    nxt(); start = 1'b0; rel = 1;
    #3 check("restart_clear", 64'({lfsr_rst_n, busy}), 64'(4'b0001));

    // Session 2: reset (together with start) in MIX.
    adv_to(2); #3 check("s2_key_bit0", 64'(lfsr_shift_bit), 64'(1'b1));
    adv_to(120); reset = 1'b1; start = 1'b1;
    nxt(); rel = 121; reset = 1'b0; start = 1'b0;
    #3 check("reset_in_mix",
             64'({lfsr_rst_n, lfsr_en, lfsr_shift_bit, ks_valid, ks_bit, busy, done}),
             64'(IDLE_VEC));

    // Session 3: timing replays after reset, then reset mid-GEN.
    start_session(K3, F3);
    #3 check("s3_clear", 64'(lfsr_rst_n), 64'(3'b000));
    adv_to(2);   #3 check("s3_key_bit0", 64'(lfsr_shift_bit), 64'(1'b0));
    adv_to(9);   #3 check("s3_key_bit7", 64'(lfsr_shift_bit), 64'(1'b1));
    adv_to(66);  #3 check("s3_frame_bit0", 64'(lfsr_shift_bit), 64'(1'b1));
    adv_to(67);  #3 check("s3_frame_bit1", 64'(lfsr_shift_bit), 64'(1'b0));
    adv_to(187); #3 check("s3_valid_before", 64'(ks_valid), 64'(1'b0));
    adv_to(188); #3 check("s3_valid_first", 64'(ks_valid), 64'(1'b1));
    while (rel < 200) begin
      nxt(); rel++;
      ks_ready = 1'($urandom_range(0, 1));
    end
    reset = 1'b1;
    nxt(); rel = 201; reset = 1'b0; ks_ready = 1'b1;
    #3 check("reset_in_gen",
             64'({lfsr_rst_n, lfsr_en, lfsr_shift_bit, ks_valid, ks_bit, busy, done}),
             64'(IDLE_VEC));
    repeat (3) nxt();
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
